stopwatch_counter: RTL and testbench

Timekeeping core of the lab3 stopwatch: turns the board clock into 1 Hz and 2 Hz enables and keeps a minutes:seconds count from 00:00 to 59:59. It supports pause and per-field adjust. It sits directly upstream of the seven-segment display driver and feeds that driver its `min` and `sec` values, plus a blink flag used for adjust-mode flashing.

---
 rtl/stopwatch_counter.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
// Timekeeping core of the stopwatch. Divides the board clock into 1 Hz and
// 2 Hz tick pulses and keeps a minutes:seconds count from 00:00 to 59:59.
// Supports run/pause toggling from a debounced button and per-field adjust.
// It also produces a blink flag that the display driver uses to flash the
// field being adjusted.
//
// Ports:
//   clk   in   board clock, all logic on its rising edge
//   rst   in   synchronous active-high reset
//   pause in   debounced pause button level; each rising edge toggles run/pause
//   adj   in   1 = adjust mode (selected field steps at 2 Hz)
//   sel   in   adjust field select: 0 = minutes, 1 = seconds
//   min   out  minutes 0..59, registered
//   sec   out  seconds 0..59, registered
//   blink out  1 = blank the selected field; always 0 outside adjust mode
// -----------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int DIV_1HZ = 100000000,
    parameter int DIV_2HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       blink
);

    localparam int C1W = (DIV_1HZ > 2) ? $clog2(DIV_1HZ) : 1;
    localparam int C2W = (DIV_2HZ > 2) ? $clog2(DIV_2HZ) : 1;
    localparam logic [C1W-1:0] C1_LAST = C1W'(DIV_1HZ - 1);
    localparam logic [C2W-1:0] C2_LAST = C2W'(DIV_2HZ - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    // Modulo-60 increment. Anything at or above 59 wraps, so an out-of-range
    // value can never persist.
    function automatic logic [5:0] inc60(input logic [5:0] v);
        logic [5:0] r;
        if (v >= 6'd59) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    logic [C1W-1:0] cnt1_q, cnt1_d;
    logic [C2W-1:0] cnt2_q, cnt2_d;
    logic           tick1_s, tick2_s;
    logic           pause_q;
    logic           pause_rise_s;
    state_t         state_q;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
    logic           blink_q, blink_d;

    // Free-running dividers; a tick is the cycle the counter sits at its terminal value.
    always_comb begin
        tick1_s = (cnt1_q == C1_LAST);
        tick2_s = (cnt2_q == C2_LAST);
        if (tick1_s) begin
            cnt1_d = '0;
        end else begin
            cnt1_d = cnt1_q + C1W'(1);
        end
        if (tick2_s) begin
            cnt2_d = '0;
        end else begin
            cnt2_d = cnt2_q + C2W'(1);
        end
    end

    // Button edge detect against the previous-cycle sample.
    always_comb begin
        pause_rise_s = pause & ~pause_q;
    end

    // Time and blink next state. The count uses the pre-toggle run state, so a
    // tick on the same edge as a pause press is still honoured.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (state_q == ST_RUN) begin
            if (adj) begin
                // Adjust: only the selected field steps, no carry between fields.
                if (tick2_s) begin
                    if (sel) begin
                        sec_d = inc60(sec_q);
                    end else begin
                        min_d = inc60(min_q);
                    end
                end else begin
                    min_d = min_q;
                    sec_d = sec_q;
                end
            end else begin
                if (tick1_s) begin
                    sec_d = inc60(sec_q);
                    if (sec_q >= 6'd59) begin
                        min_d = inc60(min_q);
                    end else begin
                        min_d = min_q;
                    end
                end else begin
                    min_d = min_q;
                    sec_d = sec_q;
                end
            end
        end else begin
            min_d = min_q;
            sec_d = sec_q;
        end

        // Blink runs in adjust mode even while paused so the user sees the field.
        if (adj) begin
            if (tick2_s) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
            end
        end else begin
            blink_d = 1'b0;
        end
    end

    // Run/pause FSM. The button sample keeps running through reset so a button
    // held across reset release is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        pause_q <= pause;
        if (rst) begin
            state_q <= ST_RUN;
        end else if (pause_rise_s) begin
            case (state_q)
                ST_RUN:    state_q <= ST_PAUSED;
                ST_PAUSED: state_q <= ST_RUN;
                default:   state_q <= ST_RUN;
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    // Divider, time and blink registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            blink_q <= 1'b0;
        end else begin
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
        end
    end

    assign min   = min_q;
    assign sec   = sec_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
// Drives stopwatch_counter (DIV_1HZ=10, DIV_2HZ=5) from a table of input
// segments. Every cycle a behavioural model predicts min/sec/blink, pushes the
// prediction to a scoreboard queue, and the DUT output is popped and compared
// after the edge. At the end of each segment the outputs are also compared to
// hand-derived values in the table.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

    localparam int D1 = 10;
    localparam int D2 = 5;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [5:0] min;
    logic [5:0] sec;
    logic       blink;

    stopwatch_counter #(
        .DIV_1HZ(D1),
        .DIV_2HZ(D2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pause(pause),
        .adj  (adj),
        .sel  (sel),
        .min  (min),
        .sec  (sec),
        .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic p;
        logic a;
        logic s;
        int   cycles;
        int   emin;
        int   esec;
        int   eblink;
    } vec_t;

    typedef struct {
        int mn;
        int sc;
        int bl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_cnt1, m_cnt2, m_min, m_sec, m_blink;
    bit m_run, m_pq;

    // Apply one cycle: predict, push, clock, pop, compare.
    task automatic step(input logic r, input logic p, input logic a, input logic s);
        exp_t e;
        exp_t got;
        bit   t1, t2;
        int   total;
        rst = r; pause = p; adj = a; sel = s;
        if (r) begin
            m_cnt1 = 0; m_cnt2 = 0; m_min = 0; m_sec = 0; m_blink = 0; m_run = 1'b1;
        end else begin
            t1 = (m_cnt1 == D1 - 1);
            t2 = (m_cnt2 == D2 - 1);
            if (m_run) begin
                if (!a && t1) begin
                    total = (m_min * 60 + m_sec + 1) % 3600;
                    m_min = total / 60;
                    m_sec = total % 60;
                end else if (a && t2) begin
                    if (s) m_sec = (m_sec + 1) % 60;
                    else   m_min = (m_min + 1) % 60;
                end
            end
            if (a) m_blink = t2 ? 1 - m_blink : m_blink;
            else   m_blink = 0;
            if (p && !m_pq) m_run = !m_run;
            m_cnt1 = (m_cnt1 + 1) % D1;
            m_cnt2 = (m_cnt2 + 1) % D2;
        end
        m_pq = p;
        e.mn = m_min; e.sc = m_sec; e.bl = m_blink;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty at t=%0t", $time);
        end else begin
            got = sb_q.pop_front();
            if (int'(min) != got.mn || int'(sec) != got.sc || int'(blink) != got.bl) begin
                errors++;
                $display("FAIL cycle t=%0t got %0d:%0d blink=%0d expected %0d:%0d blink=%0d",
                         $time, min, sec, blink, got.mn, got.sc, got.bl);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; adj = 1'b0; sel = 1'b0;
        m_cnt1 = 0; m_cnt2 = 0; m_min = 0; m_sec = 0; m_blink = 0;
        m_run = 1'b1; m_pq = 1'b0;

        //               rst   pause adj   sel  cyc  min sec blink
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,   2,  0,  0, 0}); // reset
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 610,  1,  1, 0}); // 61 seconds
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 290, 59,  1, 0}); // adjust min x58
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 285, 59, 58, 1}); // adjust sec x57
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,   1, 59, 58, 0}); // blink clears
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,   4, 59, 59, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  10,  0,  0, 0}); // full wrap
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  30,  0,  3, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,   3,  0,  3, 0}); // pause
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  50,  0,  3, 0}); // holds
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,   1,  0,  3, 0}); // resume
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,   5,  0,  3, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,   1,  0,  4, 0}); // next free tick
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,   9,  0,  4, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,   1,  0,  5, 0}); // tick + pause same edge
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  20,  0,  5, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,   1,  0,  5, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,   9,  0,  6, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 510,  0, 57, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1,  25,  0,  2, 1}); // sec 58,59,0,1,2
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  10,  2,  2, 1}); // min every 5
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,   1,  2,  2, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,   2,  0,  0, 0}); // button held in reset
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  10,  0,  1, 0}); // still RUN
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,   1,  0,  0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  60, 12,  0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 170, 12, 34, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1,   1, 12, 34, 0}); // paused in adjust
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1,   7, 12, 34, 1}); // blink, no step
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1,   1,  0,  0, 0}); // mid-op reset
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  10,  0,  1, 0}); // RUN after reset

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(vecs[i].r, vecs[i].p, vecs[i].a, vecs[i].s);
            end
            checks++;
            if (int'(min) != vecs[i].emin || int'(sec) != vecs[i].esec ||
                int'(blink) != vecs[i].eblink) begin
                errors++;
                $display("FAIL vector %0d got %0d:%0d blink=%0d expected %0d:%0d blink=%0d",
                         i, min, sec, blink, vecs[i].emin, vecs[i].esec, vecs[i].eblink);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
